// File: rtl/spi_link_pkg.sv
// Shared types and constants for the SPI slave link: FSM states,
// synchronizer depth and the default word sent when nothing is buffered.
package spi_link_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  localparam int SYNC_DEPTH = 2;

  // Sliced to WIDTH by the top; supports words up to 64 bits.
  localparam logic [63:0] DEFAULT_IDLE_WORD = '1;

endpackage

// File: rtl/spi_slave_link_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with registered
// rise/fall pulses. Edge-to-pulse latency is SYNC_DEPTH+1 clk cycles.
module sync_edge
  import spi_link_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_DEPTH-1:0] sync_q, sync_d;
  logic [SYNC_DEPTH:0]   fill_q, fill_d;
  logic                  level_q, level_d;
  logic                  rise_q, rise_d;
  logic                  fall_q, fall_d;

  // Edges stay masked until the pipeline holds only real samples, so a pin
  // that differs from RESET_VAL at reset release never fakes an edge.
  always_comb begin
    sync_d  = {sync_q[SYNC_DEPTH-2:0], async_in};
    fill_d  = {fill_q[SYNC_DEPTH-1:0], 1'b1};
    level_d = sync_q[SYNC_DEPTH-1];
    rise_d  = fill_q[SYNC_DEPTH] &  level_d & ~level_q;
    fall_d  = fill_q[SYNC_DEPTH] & ~level_d &  level_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= {SYNC_DEPTH{RESET_VAL}};
      fill_q  <= '0;
      level_q <= RESET_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      fill_q  <= fill_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/spi_slave_link.sv
// SPI mode-0 slave bridged into the clk domain: one-word transmit buffer,
// word-wide shift registers and a two-state frame FSM.
module spi_slave_link
  import spi_link_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] IDLE_WORD = DEFAULT_IDLE_WORD[WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spi_clk,
  input  logic             spi_cs,
  input  logic             spi_si,
  output logic             spi_so,
  output logic             spi_so_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             tx_underrun,
  output logic             frame_err,
  output logic             busy
);

  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic clk_rise, clk_fall, clk_level_unused;
  logic cs_rise, cs_fall, cs_level;
  logic si_level, si_rise_unused, si_fall_unused;

  sync_edge #(.RESET_VAL(1'b0)) u_sync_clk (
    .clk(clk), .rst(rst), .async_in(spi_clk),
    .level(clk_level_unused), .rise(clk_rise), .fall(clk_fall)
  );

  sync_edge #(.RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .async_in(spi_cs),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  sync_edge #(.RESET_VAL(1'b0)) u_sync_si (
    .clk(clk), .rst(rst), .async_in(spi_si),
    .level(si_level), .rise(si_rise_unused), .fall(si_fall_unused)
  );

  state_e           state_q, state_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic             buf_full_q, buf_full_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             skip_q, skip_d;
  logic [WIDTH-2:0] rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             rx_valid_q, rx_valid_d;
  logic             tx_underrun_q, tx_underrun_d;
  logic             frame_err_q, frame_err_d;
  logic             busy_q, busy_d;
  logic             so_oe_q, so_oe_d;
  logic             reload;
  logic [WIDTH-1:0] rx_word;

  // NOTE: every signal written here gets a default first, so no path
  // through the block can leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    buf_d         = buf_q;
    buf_full_d    = buf_full_q;
    shift_d       = shift_q;
    skip_d        = skip_q;
    rx_shift_d    = rx_shift_q;
    rx_data_d     = rx_data_q;
    bit_cnt_d     = bit_cnt_q;
    rx_valid_d    = 1'b0;
    tx_underrun_d = 1'b0;
    frame_err_d   = 1'b0;
    reload        = 1'b0;
    rx_word       = {rx_shift_q, si_level};

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d   = ACTIVE;
          bit_cnt_d = '0;
          reload    = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d     = IDLE;
          frame_err_d = (bit_cnt_q != '0);
          bit_cnt_d   = '0;
          skip_d      = 1'b0;
        end else begin
          if (clk_rise) begin
            rx_shift_d = rx_word[WIDTH-2:0];
            skip_d     = 1'b0;
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d  = '0;
              rx_data_d  = rx_word;
              rx_valid_d = 1'b1;
              reload     = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
          // A reload on the last rising edge already presents the new MSB.
          if (clk_fall) begin
            if (skip_q) skip_d  = 1'b0;
            else        shift_d = {shift_q[WIDTH-2:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (reload) begin
      if (buf_full_q) begin
        shift_d = buf_q;
      end else begin
        shift_d       = IDLE_WORD;
        tx_underrun_d = 1'b1;
      end
      buf_full_d = 1'b0;
      skip_d     = 1'b1;
    end

    // Acceptance looks at the pre-reload state, so a same-cycle write
    // never bypasses into the shift register.
    if (tx_valid && !buf_full_q) begin
      buf_d      = tx_data;
      buf_full_d = 1'b1;
    end

    busy_d  = (state_d == ACTIVE);
    so_oe_d = ~cs_level;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      buf_q         <= '0;
      buf_full_q    <= 1'b0;
      shift_q       <= IDLE_WORD;
      skip_q        <= 1'b0;
      rx_shift_q    <= '0;
      rx_data_q     <= '0;
      bit_cnt_q     <= '0;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      frame_err_q   <= 1'b0;
      busy_q        <= 1'b0;
      so_oe_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      buf_q         <= buf_d;
      buf_full_q    <= buf_full_d;
      shift_q       <= shift_d;
      skip_q        <= skip_d;
      rx_shift_q    <= rx_shift_d;
      rx_data_q     <= rx_data_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_valid_q    <= rx_valid_d;
      tx_underrun_q <= tx_underrun_d;
      frame_err_q   <= frame_err_d;
      busy_q        <= busy_d;
      so_oe_q       <= so_oe_d;
    end
  end

  assign spi_so      = shift_q[WIDTH-1];
  assign spi_so_oe   = so_oe_q;
  assign tx_ready    = ~buf_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = tx_underrun_q;
  assign frame_err   = frame_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_spi_slave_link.sv
// Directed bench for spi_slave_link: plays an SPI mode-0 master at clk/16
// and compares received words and status pulses with hand-computed values.
module tb_spi_slave_link;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_clk = 1'b0;
  logic       spi_cs = 1'b1;
  logic       spi_si = 1'b0;
  logic       spi_so, spi_so_oe;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, tx_underrun, frame_err, busy;

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0;
  int ur_cnt = 0;
  int fe_cnt = 0;
  logic [7:0] rx_hist[$];

  spi_slave_link #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_si(spi_si),
    .spi_so(spi_so), .spi_so_oe(spi_so_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_underrun(tx_underrun), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt++;
      rx_hist.push_back(rx_data);
    end
    if (tx_underrun) ur_cnt++;
    if (frame_err)   fe_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d);
    int n = 0;
    while (!tx_ready && n < 50) begin
      tick(1);
      n++;
    end
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_ready: tx_ready=%b required 1", tx_ready);
    end
    tx_data  = d;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
  endtask

  task automatic xfer_bit(input logic b, output logic so);
    spi_si = b;
    tick(4);
    so = spi_so;
    spi_clk = 1'b1;
    tick(8);
    spi_clk = 1'b0;
    tick(4);
  endtask

  task automatic xfer_word(input logic [7:0] mosi, output logic [7:0] miso);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(mosi[i], b);
      miso[i] = b;
    end
  endtask

  task automatic cs_low();
    spi_cs = 1'b0;
    tick(8);
  endtask

  task automatic cs_high();
    tick(4);
    spi_cs = 1'b1;
    tick(12);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    checks++;
    if ({tx_ready, rx_valid, tx_underrun, frame_err, busy, spi_so_oe, spi_so} !== 7'b1000001) begin
      errors++;
      $display("FAIL reset_flags: ready,rxv,ur,fe,busy,oe,so=%b required 1000001",
               {tx_ready, rx_valid, tx_underrun, frame_err, busy, spi_so_oe, spi_so});
    end
    checks++;
    if (rx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_rx_data: got %h required 00", rx_data);
    end
    rst = 1'b0;
    tick(5);
  endtask

  task automatic test_basic();
    logic [7:0] miso;
    int rx0, ur0;
    push(8'hA5);
    checks++;
    if (tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_full: tx_ready=%b required 0", tx_ready);
    end
    rx0 = rx_cnt;
    ur0 = ur_cnt;
    cs_low();
    checks++;
    if ({busy, spi_so_oe, tx_ready} !== 3'b111) begin
      errors++;
      $display("FAIL basic_start: busy,oe,ready=%b required 111", {busy, spi_so_oe, tx_ready});
    end
    checks++;
    if (ur_cnt - ur0 !== 0) begin
      errors++;
      $display("FAIL basic_no_underrun: pulses=%0d required 0", ur_cnt - ur0);
    end
    xfer_word(8'h3C, miso);
    cs_high();
    checks++;
    if (miso !== 8'hA5) begin
      errors++;
      $display("FAIL basic_miso: got %h required a5", miso);
    end
    checks++;
    if (rx_data !== 8'h3C || rx_cnt - rx0 !== 1) begin
      errors++;
      $display("FAIL basic_rx: rx_data=%h pulses=%0d required 3c and 1", rx_data, rx_cnt - rx0);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_end_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_underrun();
    logic [7:0] miso;
    int rx0, ur0;
    rx0 = rx_cnt;
    ur0 = ur_cnt;
    cs_low();
    checks++;
    if (ur_cnt - ur0 !== 1) begin
      errors++;
      $display("FAIL underrun_pulse: pulses=%0d required 1", ur_cnt - ur0);
    end
    xfer_word(8'h96, miso);
    cs_high();
    checks++;
    if (miso !== 8'hFF) begin
      errors++;
      $display("FAIL underrun_miso: got %h required ff", miso);
    end
    checks++;
    if (rx_data !== 8'h96 || rx_cnt - rx0 !== 1) begin
      errors++;
      $display("FAIL underrun_rx: rx_data=%h pulses=%0d required 96 and 1", rx_data, rx_cnt - rx0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] mosi1, miso1, miso2;
    logic       b;
    int rx0, h0;
    mosi1 = 8'hC3;
    push(8'h11);
    rx0 = rx_cnt;
    h0  = rx_hist.size();
    cs_low();
    for (int i = 7; i >= 0; i--) begin
      if (i == 5) push(8'h22);
      xfer_bit(mosi1[i], b);
      miso1[i] = b;
    end
    xfer_word(8'h5A, miso2);
    cs_high();
    checks++;
    if (miso1 !== 8'h11 || miso2 !== 8'h22) begin
      errors++;
      $display("FAIL b2b_miso: got %h %h required 11 22", miso1, miso2);
    end
    checks++;
    if (rx_cnt - rx0 !== 2) begin
      errors++;
      $display("FAIL b2b_rx_count: pulses=%0d required 2", rx_cnt - rx0);
    end else begin
      checks++;
      if (rx_hist[h0] !== 8'hC3 || rx_hist[h0+1] !== 8'h5A) begin
        errors++;
        $display("FAIL b2b_rx_words: got %h %h required c3 5a", rx_hist[h0], rx_hist[h0+1]);
      end
    end
  endtask

  task automatic test_frame_err();
    logic [7:0] miso;
    logic       b;
    int rx0, fe0;
    rx0 = rx_cnt;
    fe0 = fe_cnt;
    cs_low();
    for (int i = 0; i < 5; i++) xfer_bit(1'b1, b);
    cs_high();
    checks++;
    if (fe_cnt - fe0 !== 1 || rx_cnt - rx0 !== 0) begin
      errors++;
      $display("FAIL ferr_pulses: frame_err=%0d rx_valid=%0d required 1 and 0", fe_cnt - fe0, rx_cnt - rx0);
    end
    checks++;
    if (rx_data !== 8'h5A) begin
      errors++;
      $display("FAIL ferr_rx_hold: got %h required 5a", rx_data);
    end
    push(8'h77);
    rx0 = rx_cnt;
    fe0 = fe_cnt;
    cs_low();
    xfer_word(8'hE1, miso);
    cs_high();
    checks++;
    if (miso !== 8'h77 || rx_data !== 8'hE1 || rx_cnt - rx0 !== 1 || fe_cnt - fe0 !== 0) begin
      errors++;
      $display("FAIL ferr_recover: miso=%h rx=%h rxv=%0d fe=%0d required 77 e1 1 0",
               miso, rx_data, rx_cnt - rx0, fe_cnt - fe0);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] miso;
    logic       b;
    int fe0;
    push(8'h33);
    fe0 = fe_cnt;
    cs_low();
    for (int i = 0; i < 3; i++) xfer_bit(1'b0, b);
    rst = 1'b1;
    tick(3);
    checks++;
    if ({tx_ready, rx_valid, tx_underrun, frame_err, busy, spi_so_oe, spi_so} !== 7'b1000001
        || rx_data !== 8'h00) begin
      errors++;
      $display("FAIL midrst_values: ready,rxv,ur,fe,busy,oe,so=%b rx=%h required 1000001 00",
               {tx_ready, rx_valid, tx_underrun, frame_err, busy, spi_so_oe, spi_so}, rx_data);
    end
    rst = 1'b0;
    tick(12);
    checks++;
    if (busy !== 1'b0 || fe_cnt - fe0 !== 0) begin
      errors++;
      $display("FAIL midrst_wait: busy=%b frame_err=%0d required 0 and 0", busy, fe_cnt - fe0);
    end
    cs_high();
    push(8'h4B);
    cs_low();
    xfer_word(8'h2D, miso);
    cs_high();
    checks++;
    if (miso !== 8'h4B || rx_data !== 8'h2D) begin
      errors++;
      $display("FAIL midrst_recover: miso=%h rx=%h required 4b 2d", miso, rx_data);
    end
  endtask

  task automatic test_hold_full();
    logic [7:0] miso;
    int bad = 0;
    push(8'h6E);
    tx_data  = 8'h99;
    tx_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (tx_ready !== 1'b0) bad++;
    end
    tx_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold_ready: tx_ready high in %0d cycles required 0", bad);
    end
    cs_low();
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_reload: tx_ready=%b required 1", tx_ready);
    end
    xfer_word(8'h00, miso);
    cs_high();
    checks++;
    if (miso !== 8'h6E) begin
      errors++;
      $display("FAIL hold_word: got %h required 6e", miso);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underrun();
    test_back_to_back();
    test_frame_err();
    test_reset_mid_frame();
    test_hold_full();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
